// File: rtl/access_sequencer.sv
// rtl/access_sequencer.sv - authorised-ID table scanner with optional lockout (ACCESS_LOCKOUT_EN)
module access_sequencer #(
    parameter int NUM_IDS     = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_IDS)-1:0] cfg_idx,
    input  logic [23:0]                cfg_id,
    input  logic                       cfg_en,
    input  logic                       req_valid,
    input  logic [23:0]                req_id,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic                       access_granted,
    output logic                       access_denied,
    output logic                       locked,
    output logic                       irq_flag,
    input  logic                       irq_clr
);
    localparam int               IDX_W    = $clog2(NUM_IDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESULT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [23:0]      tbl_id [NUM_IDS];
    logic             tbl_en [NUM_IDS];
    logic [IDX_W-1:0] scan_idx, scan_idx_nxt;
    logic [23:0]      cap_id, cap_id_nxt;
    logic             ready_nxt, rsp_nxt, granted_nxt, denied_nxt, irq_set;
    logic             hit;

`ifdef ACCESS_LOCKOUT_EN
    localparam int                FAIL_W   = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
    logic [FAIL_W-1:0] fail_cnt, fail_cnt_nxt;
    logic [15:0]       lock_tmr, lock_tmr_nxt;
    logic              locked_nxt;
`else
    assign locked = 1'b0;
`endif

    // Table writes land at the edge, so a compare in the same cycle sees the old entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                tbl_id[i] <= '0;
                tbl_en[i] <= 1'b0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_IDS)) begin
            tbl_id[cfg_idx] <= cfg_id;
            tbl_en[cfg_idx] <= cfg_en;
        end
    end

    assign hit = tbl_en[scan_idx] && (tbl_id[scan_idx] == cap_id);

    // Next state plus next values of every registered output
    always_comb begin
        state_nxt    = state;
        scan_idx_nxt = scan_idx;
        cap_id_nxt   = cap_id;
        ready_nxt    = 1'b0;
        rsp_nxt      = 1'b0;
        granted_nxt  = 1'b0;
        denied_nxt   = 1'b0;
        irq_set      = 1'b0;
`ifdef ACCESS_LOCKOUT_EN
        locked_nxt   = 1'b0;
        fail_cnt_nxt = fail_cnt;
        lock_tmr_nxt = lock_tmr;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    cap_id_nxt   = req_id;
                    scan_idx_nxt = '0;
                    state_nxt    = ST_COMPARE;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            ST_COMPARE: begin
                if (hit) begin
                    state_nxt   = ST_RESULT;
                    rsp_nxt     = 1'b1;
                    granted_nxt = 1'b1;
`ifdef ACCESS_LOCKOUT_EN
                    fail_cnt_nxt = '0;
`endif
                end else if (scan_idx == LAST_IDX) begin
                    state_nxt  = ST_RESULT;
                    rsp_nxt    = 1'b1;
                    denied_nxt = 1'b1;
                    irq_set    = 1'b1;
`ifdef ACCESS_LOCKOUT_EN
                    if (fail_cnt != FAIL_MAX) begin
                        fail_cnt_nxt = fail_cnt + 1'b1;
                    end
`endif
                end else begin
                    scan_idx_nxt = scan_idx + 1'b1;
                end
            end
            ST_RESULT: begin
`ifdef ACCESS_LOCKOUT_EN
                if (access_denied && (fail_cnt == FAIL_MAX)) begin
                    state_nxt    = ST_LOCKOUT;
                    locked_nxt   = 1'b1;
                    irq_set      = 1'b1;
                    lock_tmr_nxt = 16'(LOCK_CYCLES - 1);
                end else begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                end
`else
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
`endif
            end
            ST_LOCKOUT: begin
`ifdef ACCESS_LOCKOUT_EN
                if (lock_tmr == 16'd0) begin
                    state_nxt    = ST_IDLE;
                    ready_nxt    = 1'b1;
                    fail_cnt_nxt = '0;
                end else begin
                    lock_tmr_nxt = lock_tmr - 1'b1;
                    locked_nxt   = 1'b1;
                end
`else
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // State, capture and output registers; irq set wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            scan_idx       <= '0;
            cap_id         <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            access_granted <= 1'b0;
            access_denied  <= 1'b0;
            irq_flag       <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            locked         <= 1'b0;
            fail_cnt       <= '0;
            lock_tmr       <= '0;
`endif
        end else begin
            state          <= state_nxt;
            scan_idx       <= scan_idx_nxt;
            cap_id         <= cap_id_nxt;
            req_ready      <= ready_nxt;
            rsp_valid      <= rsp_nxt;
            access_granted <= granted_nxt;
            access_denied  <= denied_nxt;
            irq_flag       <= irq_set | (irq_flag & ~irq_clr);
`ifdef ACCESS_LOCKOUT_EN
            locked         <= locked_nxt;
            fail_cnt       <= fail_cnt_nxt;
            lock_tmr       <= lock_tmr_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_access_sequencer.sv
// tb/tb_access_sequencer.sv - randomized and directed bench for access_sequencer against a behavioural model
module tb_access_sequencer;
    localparam int N  = 4;
    localparam int MF = 3;
    localparam int LC = 10;
`ifdef ACCESS_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [23:0] cfg_id = '0;
    logic        cfg_en = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_id = '0;
    logic        irq_clr = 1'b0;
    logic        req_ready, rsp_valid, access_granted, access_denied, locked, irq_flag;

    int checks = 0;
    int errors = 0;

    access_sequencer #(.NUM_IDS(N), .MAX_FAILS(MF), .LOCK_CYCLES(LC)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_id(cfg_id),
        .cfg_en(cfg_en), .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .access_granted(access_granted), .access_denied(access_denied),
        .locked(locked), .irq_flag(irq_flag), .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    // Behavioural model: table contents, scan position, fail tally, lockout countdown
    logic [23:0] m_id [N];
    bit          m_en [N];
    int          m_scan;
    logic [23:0] m_cap;
    int          m_fails, m_lock_left;
    bit          e_ready = 1'b1, e_rsp, e_gr, e_dn, e_lk, e_irq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_id[i] = '0;
                m_en[i] = 1'b0;
            end
            m_scan = -1; m_cap = '0; m_fails = 0; m_lock_left = 0;
            e_ready = 1'b1; e_rsp = 1'b0; e_gr = 1'b0; e_dn = 1'b0; e_lk = 1'b0; e_irq = 1'b0;
        end else begin
            bit set_irq, was_rsp, was_dn;
            set_irq = 1'b0;
            was_rsp = e_rsp;
            was_dn  = e_dn;
            e_rsp = 1'b0; e_gr = 1'b0; e_dn = 1'b0;
            if (e_lk) begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    e_lk = 1'b0; e_ready = 1'b1; m_fails = 0;
                end
            end else if (was_rsp) begin
                if (LOCK_EN && was_dn && m_fails >= MF) begin
                    e_lk = 1'b1; m_lock_left = LC; set_irq = 1'b1;
                end else begin
                    e_ready = 1'b1;
                end
            end else if (m_scan >= 0) begin
                if (m_en[m_scan] && m_id[m_scan] == m_cap) begin
                    e_rsp = 1'b1; e_gr = 1'b1; m_fails = 0; m_scan = -1;
                end else if (m_scan == N - 1) begin
                    e_rsp = 1'b1; e_dn = 1'b1; set_irq = 1'b1; m_scan = -1;
                    if (m_fails < MF) m_fails++;
                end else begin
                    m_scan++;
                end
            end else if (req_valid) begin
                m_cap = req_id; m_scan = 0; e_ready = 1'b0;
            end
            e_irq = set_irq | (e_irq & ~irq_clr);
            if (cfg_we) begin
                m_id[cfg_idx] = cfg_id;
                m_en[cfg_idx] = cfg_en;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        checks++;
        if ({req_ready, rsp_valid, access_granted, access_denied, locked, irq_flag} !==
            {e_ready, e_rsp, e_gr, e_dn, e_lk, e_irq}) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t actual(rdy,rsp,gr,dn,lk,irq)=%b required=%b", $time,
                     {req_ready, rsp_valid, access_granted, access_denied, locked, irq_flag},
                     {e_ready, e_rsp, e_gr, e_dn, e_lk, e_irq});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input logic [23:0] id, input logic en);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_id = id; cfg_en = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", 32'(req_ready), 32'd1);
    endtask

    // Submit one ID; optional table write / irq_clr in the cycle before relative edge wr_at / clr_at
    task automatic submit(input logic [23:0] id, input int wr_at, input int wr_idx,
                          input logic [23:0] wr_id, input logic wr_en, input int clr_at,
                          output int lat, output logic gr, output logic dn);
        wait_ready();
        req_valid = 1'b1; req_id = id;
        lat = -1; gr = 1'b0; dn = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_id = 24'($urandom);
            cfg_we = (c == wr_at);
            if (c == wr_at) begin
                cfg_idx = 2'(wr_idx); cfg_id = wr_id; cfg_en = wr_en;
            end
            irq_clr = (c == clr_at);
            if (rsp_valid) begin
                lat = c - 1; gr = access_granted; dn = access_denied;
            end
        end
        cfg_we = 1'b0; irq_clr = 1'b0;
        chk("rsp_seen", 32'(lat >= 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, seen;
        logic gr, dn;
        logic [23:0] pool [6];
        pool[0] = 24'hABCDEF; pool[1] = 24'h123456; pool[2] = 24'h000000;
        pool[3] = 24'h5A5A5A; pool[4] = 24'h777777; pool[5] = 24'hFFFFFF;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({req_ready, rsp_valid, access_granted, access_denied, locked, irq_flag}), 32'b100000);
        rst = 1'b0;

        // Empty table: zero ID is denied after NUM_IDS edges
        submit(24'h000000, -1, 0, 0, 0, -1, lat, gr, dn);
        chk("empty_deny_latency", 32'(lat), 32'd4);
        chk("empty_deny_flag", 32'({gr, dn}), 32'b01);
        chk("deny_irq_set", 32'(irq_flag), 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_cleared", 32'(irq_flag), 32'd0);

        // Match in entry 2
        cfg_write(2, 24'hABCDEF, 1'b1);
        submit(24'hABCDEF, -1, 0, 0, 0, -1, lat, gr, dn);
        chk("grant_latency", 32'(lat), 32'd3);
        chk("grant_flag", 32'({gr, dn}), 32'b10);
        chk("grant_no_irq", 32'(irq_flag), 32'd0);

        // Disabling entry 0 at the edge it is compared still grants; next request denied
        cfg_write(0, 24'h123456, 1'b1);
        submit(24'h123456, 1, 0, 24'h123456, 1'b0, -1, lat, gr, dn);
        chk("pre_write_grant_latency", 32'(lat), 32'd1);
        chk("pre_write_grant_flag", 32'({gr, dn}), 32'b10);
        submit(24'h123456, -1, 0, 0, 0, -1, lat, gr, dn);
        chk("post_write_deny_latency", 32'(lat), 32'd4);
        chk("post_write_deny_flag", 32'({gr, dn}), 32'b01);

        // irq_clr in the same cycle as a deny leaves the flag set
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_pre_clear", 32'(irq_flag), 32'd0);
        submit(24'h777777, -1, 0, 0, 0, 4, lat, gr, dn);
        chk("set_clr_collision_deny", 32'({gr, dn}), 32'b01);
        chk("set_clr_collision_irq", 32'(irq_flag), 32'd1);
        @(negedge clk);
        chk("set_clr_collision_irq_hold", 32'(irq_flag), 32'd1);

`ifdef ACCESS_LOCKOUT_EN
        // A grant clears the tally; the third consecutive deny locks for LC cycles
        submit(24'hABCDEF, -1, 0, 0, 0, -1, lat, gr, dn);
        submit(24'h777777, -1, 0, 0, 0, -1, lat, gr, dn);
        submit(24'h777777, -1, 0, 0, 0, -1, lat, gr, dn);
        submit(24'hABCDEF, -1, 0, 0, 0, -1, lat, gr, dn);
        chk("grant_between_fails", 32'({gr, dn}), 32'b10);
        submit(24'h777777, -1, 0, 0, 0, -1, lat, gr, dn);
        submit(24'h777777, -1, 0, 0, 0, -1, lat, gr, dn);
        @(negedge clk);
        chk("two_fails_not_locked", 32'({locked, req_ready}), 32'b01);
        submit(24'h777777, -1, 0, 0, 0, -1, lat, gr, dn);
        @(negedge clk);
        chk("lock_entry", 32'({locked, req_ready, irq_flag}), 32'b101);
        n = 0;
        while (locked && n < 100) begin
            if (req_ready) chk("ready_low_in_lock", 32'(req_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        chk("lock_duration", 32'(n), 32'(LC));
        chk("lock_exit_ready", 32'({locked, req_ready}), 32'b01);
`else
        // Without lockout, repeated denies never lock
        repeat (4) begin
            submit(24'h777777, -1, 0, 0, 0, -1, lat, gr, dn);
            @(negedge clk);
            chk("no_lockout_build", 32'({locked, req_ready}), 32'b01);
        end
`endif

        // Randomized traffic checked cycle by cycle against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid = ($urandom_range(2) == 0);
            req_id    = pool[$urandom_range(5)];
            cfg_we    = ($urandom_range(7) == 0);
            cfg_idx   = 2'($urandom_range(3));
            cfg_id    = pool[$urandom_range(5)];
            cfg_en    = 1'($urandom_range(1));
            irq_clr   = ($urandom_range(9) == 0);
            @(negedge clk);
        end
        req_valid = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0;

        // Reset in the middle of a compare
        cfg_write(0, 24'h000001, 1'b0);
        cfg_write(1, 24'h000001, 1'b0);
        cfg_write(2, 24'h000001, 1'b0);
        cfg_write(3, 24'h5A5A5A, 1'b1);
        wait_ready();
        req_valid = 1'b1; req_id = 24'h5A5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_compare_busy", 32'({req_ready, rsp_valid}), 32'b00);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({req_ready, rsp_valid, access_granted, access_denied, locked, irq_flag}), 32'b100000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_abort", 32'(seen), 32'd0);
        submit(24'h5A5A5A, -1, 0, 0, 0, -1, lat, gr, dn);
        chk("table_cleared_deny", 32'({gr, dn}), 32'b01);
        chk("table_cleared_latency", 32'(lat), 32'd4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
